// File: rtl/cpu_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_ctrl
//   Fetch/decode/sequencing stage for a single-cycle accumulator CPU. Holds
//   the program counter, drives the program-memory address, decodes the
//   instruction word returned by an asynchronous ROM and drives every
//   datapath control. Supports JMP/JZ/JNZ/CALL/RET with a small return stack
//   and a HALT state that only reset can leave.
//
// Optional feature (macro CPU_CTRL_STEP_EN):
//   When defined, an extra STEP input gates execution. Instructions execute
//   only in RUN cycles with STEP=1. With STEP=0 nothing advances and all
//   enables stay 0, but HALTED is not asserted.
//
// Ports
//   CLK              in   clock, rising edge
//   RST              in   synchronous reset, active-high
//   P_ADDR           out  program-memory address (= PC)
//   INSTR            in   {OPC, MODE[1:0], OPND}
//   ACC_VAL          in   accumulator value, tested by JZ/JNZ
//   REG_F_SEL        out  register-file select = OPND[SEL_SIZE-1:0]
//   EN_REG_F         out  write ACC into selected register
//   D_MEM_ADDR       out  direct data-memory address = OPND
//   D_MEM_ADDR_MODE  out  0 = address from OPND, 1 = address from register
//   EN_D_MEM         out  write ACC into data memory
//   IN_B_SEL         out  ALU B-input mux: 00 IMM, 01 REG, 1x DMEM
//   IMM              out  immediate = OPND
//   ALU_OUT          out  ALU operation
//   EN_ACC           out  load ALU result into ACC
//   HALTED           out  core stopped
//   STK_ERR          out  sticky return-stack overflow/underflow
//   STEP             in   (CPU_CTRL_STEP_EN only) execute this cycle
// ---------------------------------------------------------------------------
module cpu_ctrl #(
    parameter int WIDTH       = 8,
    parameter int IWIDTH      = 5,
    parameter int PC_WIDTH    = 8,
    parameter int SEL_SIZE    = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    output logic [PC_WIDTH-1:0]       P_ADDR,
    input  logic [IWIDTH+2+WIDTH-1:0] INSTR,
    input  logic [WIDTH-1:0]          ACC_VAL,
    output logic [SEL_SIZE-1:0]       REG_F_SEL,
    output logic                      EN_REG_F,
    output logic [WIDTH-1:0]          D_MEM_ADDR,
    output logic                      D_MEM_ADDR_MODE,
    output logic                      EN_D_MEM,
    output logic [1:0]                IN_B_SEL,
    output logic [WIDTH-1:0]          IMM,
    output logic [IWIDTH-2:0]         ALU_OUT,
    output logic                      EN_ACC,
    output logic                      HALTED,
    output logic                      STK_ERR
`ifdef CPU_CTRL_STEP_EN
    ,
    input  logic                      STEP
`endif
);

    // SP counts 0..STACK_DEPTH, so it needs one more code than the index.
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    localparam logic [0:0] STATE_RUN  = 1'b0;
    localparam logic [0:0] STATE_HALT = 1'b1;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ST   = 4'd1;
    localparam logic [3:0] OP_STM  = 4'd2;
    localparam logic [3:0] OP_JMP  = 4'd3;
    localparam logic [3:0] OP_JZ   = 4'd4;
    localparam logic [3:0] OP_JNZ  = 4'd5;
    localparam logic [3:0] OP_CALL = 4'd6;
    localparam logic [3:0] OP_RET  = 4'd7;
    localparam logic [3:0] OP_HALT = 4'd8;

    function automatic logic [PC_WIDTH-1:0] pc_wrap_inc(input logic [PC_WIDTH-1:0] v);
        return v + 1'b1;
    endfunction

    logic [0:0]          state, state_next;
    logic [PC_WIDTH-1:0] pc, pc_next, pc_inc, target;
    logic [SP_W-1:0]     sp, sp_next;
    logic                stk_err, err_set, push;
    logic [PC_WIDTH-1:0] stack [STACK_DEPTH];

    logic [IWIDTH-1:0]   opc;
    logic [1:0]          mode;
    logic [WIDTH-1:0]    opnd;
    logic                is_ctrl;
    logic [3:0]          code;
    logic                go;
    logic                active;

    assign {opc, mode, opnd} = INSTR;
    assign is_ctrl = opc[IWIDTH-1];
    assign code    = opc[3:0];
    assign pc_inc  = pc_wrap_inc(pc);
    assign target  = PC_WIDTH'(opnd);

`ifdef CPU_CTRL_STEP_EN
    assign go = STEP;
`else
    assign go = 1'b1;
`endif

    // Reset overrides everything in the current cycle, including stack pushes.
    assign active = (state == STATE_RUN) && !RST && go;

    // Datapath controls: purely combinational decode of the current word.
    always_comb begin
        P_ADDR          = pc;
        REG_F_SEL       = opnd[SEL_SIZE-1:0];
        D_MEM_ADDR      = opnd;
        IMM             = opnd;
        IN_B_SEL        = mode;
        D_MEM_ADDR_MODE = (mode == 2'b11);
        ALU_OUT         = is_ctrl ? '0 : opc[IWIDTH-2:0];
        EN_ACC          = active && !is_ctrl;
        EN_REG_F        = active && is_ctrl && (code == OP_ST);
        EN_D_MEM        = active && is_ctrl && (code == OP_STM);
        HALTED          = (state == STATE_HALT);
        STK_ERR         = stk_err;
    end

    // Sequencing: next PC / SP / state.
    always_comb begin
        pc_next    = pc;
        sp_next    = sp;
        state_next = state;
        err_set    = 1'b0;
        push       = 1'b0;
        if (active) begin
            pc_next = pc_inc;
            if (is_ctrl) begin
                case (code)
                    OP_JMP: pc_next = target;
                    OP_JZ:  if (ACC_VAL == '0) pc_next = target;
                    OP_JNZ: if (ACC_VAL != '0) pc_next = target;
                    OP_CALL: begin
                        if (sp == SP_FULL) begin
                            pc_next    = pc;
                            err_set    = 1'b1;
                            state_next = STATE_HALT;
                        end else begin
                            push    = 1'b1;
                            sp_next = sp + 1'b1;
                            pc_next = target;
                        end
                    end
                    OP_RET: begin
                        if (sp == '0) begin
                            pc_next    = pc;
                            err_set    = 1'b1;
                            state_next = STATE_HALT;
                        end else begin
                            sp_next = sp - 1'b1;
                            pc_next = stack[IDX_W'(sp - 1'b1)];
                        end
                    end
                    OP_HALT: begin
                        pc_next    = pc;
                        state_next = STATE_HALT;
                    end
                    // NOP, ST, STM and reserved codes just advance the PC.
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc      <= '0;
            sp      <= '0;
            state   <= STATE_RUN;
            stk_err <= 1'b0;
        end else begin
            pc    <= pc_next;
            sp    <= sp_next;
            state <= state_next;
            if (err_set) stk_err <= 1'b1;
        end
    end

    // Stack contents are data: no reset, written only on a successful CALL.
    always_ff @(posedge CLK) begin
        if (push) stack[IDX_W'(sp)] <= pc_inc;
    end

endmodule
